// File: rtl/segdisp_pkg.sv
// ---------------------------------------------------------------------------
// segdisp_pkg
// Shared definitions for the seven-segment display path.
//   seg_state_e : arbiter ownership state (idle / in hold window / open)
//   BLANK_ALL   : blank mask that darkens all four digits; the scanner
//                 uses the same constant for its own idle display.
// ---------------------------------------------------------------------------
package segdisp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_OPEN = 2'd2
    } seg_state_e;

    localparam logic [3:0] BLANK_ALL = 4'b1111;

endpackage

// File: rtl/segdisp_tick.sv
// ---------------------------------------------------------------------------
// segdisp_tick
// Free-running prescaler. It counts 0..TICK_DIV-1 and wraps. tick_o is high
// for exactly one cycle while the count sits at TICK_DIV-1.
//   i_clock   : clock
//   nreset_i  : synchronous active-low reset (count returns to 0)
//   tick_o    : one-cycle pulse every TICK_DIV cycles
// ---------------------------------------------------------------------------
module segdisp_tick #(
    parameter int TICK_DIV = 50000
) (
    input  logic i_clock,
    input  logic nreset_i,
    output logic tick_o
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick_o = (cnt_q == CNT_LAST);
    assign cnt_d  = tick_o ? '0 : cnt_q + CNT_W'(1);

    always_ff @(posedge i_clock) begin
        if (!nreset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/segdisp_arbiter.sv
// ---------------------------------------------------------------------------
// segdisp_arbiter
// Shares the 4-digit multiplexed display between N_REQ requesters. Ownership
// rotates round-robin, every new grant is held for a minimum number of
// prescaler ticks, and requester 0 may optionally preempt immediately.
//   i_clock            : clock
//   nreset_i           : synchronous active-low reset
//   req_i[N_REQ]       : request level per requester
//   data_i[N_REQ][16]  : hex value per requester, [15:12] is the left digit
//   gnt_o[N_REQ]       : one-hot owner, zero when idle
//   data_dig_0..3      : nibbles to the scanner (digit 0 is rightmost)
//   blank_o[4]         : 1 = digit dark, bit i matches data_dig_i
//   busy_o             : a grant is active
// All outputs are registered; the display path follows the next owner so
// data and grant change on the same edge.
// ---------------------------------------------------------------------------
module segdisp_arbiter
    import segdisp_pkg::*;
#(
    parameter int N_REQ      = 3,
    parameter int TICK_DIV   = 50000,
    parameter int HOLD_TICKS = 1000,
    parameter int PREEMPT0   = 1,
    parameter int LZ_BLANK   = 1
) (
    input  logic                   i_clock,
    input  logic                   nreset_i,
    input  logic [N_REQ-1:0]       req_i,
    input  logic [N_REQ-1:0][15:0] data_i,
    output logic [N_REQ-1:0]       gnt_o,
    output logic [3:0]             data_dig_0,
    output logic [3:0]             data_dig_1,
    output logic [3:0]             data_dig_2,
    output logic [3:0]             data_dig_3,
    output logic [3:0]             blank_o,
    output logic                   busy_o
);

    localparam int IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int HOLD_W = $clog2(HOLD_TICKS + 1);

    // Returns {found, index}: first requester set, scanning upward from
    // last+1 and wrapping. Nearest offset is visited last so it wins.
    function automatic logic [IDX_W:0] rr_pick(input logic [N_REQ-1:0] req,
                                               input logic [IDX_W-1:0] last);
        logic [IDX_W:0]   res;
        logic [IDX_W-1:0] k;
        res = '0;
        for (int i = N_REQ; i >= 1; i--) begin
            k = IDX_W'((int'(last) + i) % N_REQ);
            if (req[k]) res = {1'b1, k};
        end
        return res;
    endfunction

    // Digit k (3..1) is dark when it and every digit to its left are zero.
    function automatic logic [3:0] lz_mask(input logic [15:0] v);
        logic [3:0] m;
        m[3] = (v[15:12] == 4'h0);
        m[2] = m[3] & (v[11:8] == 4'h0);
        m[1] = m[2] & (v[7:4] == 4'h0);
        m[0] = 1'b0;
        return m;
    endfunction

    seg_state_e       state_q, state_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [N_REQ-1:0] gnt_q;
    logic [15:0]      dig_q;
    logic [3:0]       blank_q;
    logic             busy_q;

    logic             tick;
    logic             grant_new;
    logic             busy_d;
    logic [N_REQ-1:0] owner_oh;
    logic [IDX_W:0]   pick_any;
    logic [IDX_W:0]   pick_oth;
    logic [15:0]      sel_data;

    segdisp_tick #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .i_clock  (i_clock),
        .nreset_i (nreset_i),
        .tick_o   (tick)
    );

    assign owner_oh = {{(N_REQ-1){1'b0}}, 1'b1} << owner_q;
    assign pick_any = rr_pick(req_i, owner_q);
    assign pick_oth = rr_pick(req_i & ~owner_oh, owner_q);

    // owner_q doubles as the round-robin "last owner" pointer; it keeps its
    // value through IDLE so the next pick continues the rotation.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        hold_d    = hold_q;
        grant_new = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (pick_any[IDX_W]) begin
                    grant_new = 1'b1;
                    owner_d   = pick_any[IDX_W-1:0];
                end
            end
            default: begin
                if ((PREEMPT0 != 0) && req_i[0] && (owner_q != '0)) begin
                    grant_new = 1'b1;
                    owner_d   = '0;
                end else if (!req_i[owner_q]) begin
                    if (pick_any[IDX_W]) begin
                        grant_new = 1'b1;
                        owner_d   = pick_any[IDX_W-1:0];
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if ((state_q == ST_OPEN) && pick_oth[IDX_W]) begin
                    grant_new = 1'b1;
                    owner_d   = pick_oth[IDX_W-1:0];
                end else if ((state_q == ST_HOLD) && tick) begin
                    hold_d = (hold_q != '0) ? hold_q - HOLD_W'(1) : '0;
                    if (hold_q <= HOLD_W'(1)) state_d = ST_OPEN;
                end
            end
        endcase
        if (grant_new) begin
            state_d = ST_HOLD;
            hold_d  = HOLD_W'(HOLD_TICKS);
        end
    end

    assign busy_d   = (state_d != ST_IDLE);
    assign sel_data = data_i[owner_d];

    always_ff @(posedge i_clock) begin
        if (!nreset_i) begin
            state_q <= ST_IDLE;
            owner_q <= IDX_W'(N_REQ - 1);
            hold_q  <= '0;
            gnt_q   <= '0;
            busy_q  <= 1'b0;
            dig_q   <= '0;
            blank_q <= BLANK_ALL;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            hold_q  <= hold_d;
            busy_q  <= busy_d;
            if (busy_d) begin
                gnt_q   <= {{(N_REQ-1){1'b0}}, 1'b1} << owner_d;
                dig_q   <= sel_data;
                blank_q <= (LZ_BLANK != 0) ? lz_mask(sel_data) : 4'b0000;
            end else begin
                gnt_q   <= '0;
                dig_q   <= '0;
                blank_q <= BLANK_ALL;
            end
        end
    end

    assign gnt_o      = gnt_q;
    assign busy_o     = busy_q;
    assign data_dig_0 = dig_q[3:0];
    assign data_dig_1 = dig_q[7:4];
    assign data_dig_2 = dig_q[11:8];
    assign data_dig_3 = dig_q[15:12];
    assign blank_o    = blank_q;

endmodule

// File: tb/tb_segdisp_arbiter.sv
// ---------------------------------------------------------------------------
// tb_segdisp_arbiter
// Three arbiters share one stimulus: the main instance (preempt on, leading
// zero blanking on), one with preemption off and one with blanking off.
// Expected values are queued when stimulus is applied and popped after the
// clock edge that should produce them.
// ---------------------------------------------------------------------------
module tb_segdisp_arbiter;

    localparam int N = 3;

    typedef struct packed {
        logic [23:0] v;          // {gnt, busy, dig3..dig0, blank} of main
        logic [2:0]  np_gnt;     // grant of the no-preempt instance
        logic [3:0]  nlz_blank;  // blank mask of the no-blanking instance
    } exp_t;

    logic clk = 1'b0;
    logic nrst;
    logic [N-1:0] req;
    logic [15:0]  d0, d1, d2;
    logic [N-1:0][15:0] data;

    logic [N-1:0] g_m, g_n, g_z;
    logic [3:0]   dm [4];
    logic [3:0]   dn [4];
    logic [3:0]   dz [4];
    logic [3:0]   bl_m, bl_n, bl_z;
    logic         b_m, b_n, b_z;
    logic [23:0]  obs_m;

    int checks   = 0;
    int failures = 0;
    exp_t sb[$];

    assign data  = {d2, d1, d0};
    assign obs_m = {g_m, b_m, dm[3], dm[2], dm[1], dm[0], bl_m};

    always #5 clk = ~clk;

    segdisp_arbiter #(.N_REQ(N), .TICK_DIV(4), .HOLD_TICKS(3), .PREEMPT0(1), .LZ_BLANK(1)) u_main (
        .i_clock(clk), .nreset_i(nrst), .req_i(req), .data_i(data), .gnt_o(g_m),
        .data_dig_0(dm[0]), .data_dig_1(dm[1]), .data_dig_2(dm[2]), .data_dig_3(dm[3]),
        .blank_o(bl_m), .busy_o(b_m));

    segdisp_arbiter #(.N_REQ(N), .TICK_DIV(4), .HOLD_TICKS(3), .PREEMPT0(0), .LZ_BLANK(1)) u_np (
        .i_clock(clk), .nreset_i(nrst), .req_i(req), .data_i(data), .gnt_o(g_n),
        .data_dig_0(dn[0]), .data_dig_1(dn[1]), .data_dig_2(dn[2]), .data_dig_3(dn[3]),
        .blank_o(bl_n), .busy_o(b_n));

    segdisp_arbiter #(.N_REQ(N), .TICK_DIV(4), .HOLD_TICKS(3), .PREEMPT0(1), .LZ_BLANK(0)) u_nlz (
        .i_clock(clk), .nreset_i(nrst), .req_i(req), .data_i(data), .gnt_o(g_z),
        .data_dig_0(dz[0]), .data_dig_1(dz[1]), .data_dig_2(dz[2]), .data_dig_3(dz[3]),
        .blank_o(bl_z), .busy_o(b_z));

    function automatic logic [23:0] ev(input logic [2:0] g, input logic [15:0] dig,
                                       input logic [3:0] bl);
        return {g, |g, dig, bl};
    endfunction

    // Two reset edges, then release; the prescaler phase is 0 at the next edge.
    task automatic do_reset();
        nrst = 1'b0;
        req  = '0;
        repeat (2) @(posedge clk);
        #1;
        nrst = 1'b1;
    endtask

    task automatic test_reset();
        exp_t e;
        d0 = 16'h1111; d1 = 16'h2222; d2 = 16'h3333;
        for (int c = 0; c < 3; c++) begin
            nrst = (c == 2);
            req  = (c == 2) ? 3'b000 : 3'b111;
            e.v = ev(3'b000, 16'h0000, 4'b1111);
            e.np_gnt = 3'b000;
            e.nlz_blank = 4'b1111;
            sb.push_back(e);
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if (obs_m !== e.v) begin
                failures++;
                $display("FAIL reset_main c=%0d got=%h want=%h", c, obs_m, e.v);
            end
            checks++;
            if ({g_n, b_n, bl_z} !== {e.np_gnt, 1'b0, e.nlz_blank}) begin
                failures++;
                $display("FAIL reset_variants c=%0d got=%b want=%b", c, {g_n, b_n, bl_z},
                         {e.np_gnt, 1'b0, e.nlz_blank});
            end
        end
    endtask

    // Grant from idle, hold enforcement, live data, release with wrap, idle.
    task automatic test_grant_hold();
        exp_t e;
        logic [2:0] g;
        logic [15:0] dv;
        logic [3:0] bl;
        do_reset();
        d0 = 16'h0BEE; d1 = 16'h00A5; d2 = 16'h1234;
        for (int c = 0; c < 16; c++) begin
            if (c == 5) d1 = 16'h0C05;
            if (c == 0)       req = 3'b010;
            else if (c < 13)  req = 3'b110;
            else if (c == 13) req = 3'b011;
            else if (c == 14) req = 3'b010;
            else              req = 3'b000;
            if (c < 12) begin
                g = 3'b010; dv = (c < 5) ? 16'h00A5 : 16'h0C05; bl = (c < 5) ? 4'b1100 : 4'b1000;
            end else if (c == 12) begin
                g = 3'b100; dv = 16'h1234; bl = 4'b0000;
            end else if (c == 13) begin
                g = 3'b001; dv = 16'h0BEE; bl = 4'b1000;
            end else if (c == 14) begin
                g = 3'b010; dv = 16'h0C05; bl = 4'b1000;
            end else begin
                g = 3'b000; dv = 16'h0000; bl = 4'b1111;
            end
            e.v = ev(g, dv, bl);
            e.np_gnt = g;
            e.nlz_blank = (g == 3'b000) ? 4'b1111 : 4'b0000;
            sb.push_back(e);
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if (obs_m !== e.v) begin
                failures++;
                $display("FAIL grant_hold c=%0d got=%h want=%h", c, obs_m, e.v);
            end
            checks++;
            if (g_n !== e.np_gnt) begin
                failures++;
                $display("FAIL grant_hold_np c=%0d got=%b want=%b", c, g_n, e.np_gnt);
            end
        end
    endtask

    // Requester 0 rises while 2 is in hold: main switches at once, the
    // no-preempt instance waits for the hold window to expire.
    task automatic test_preempt();
        exp_t e;
        logic [2:0] g;
        logic [15:0] dv;
        logic [3:0] bl;
        do_reset();
        d0 = 16'h0BEE; d1 = 16'h00A5; d2 = 16'h1234;
        for (int c = 0; c < 14; c++) begin
            if (c == 0)      req = 3'b100;
            else if (c < 13) req = 3'b101;
            else             req = 3'b000;
            if (c == 0 || c == 12) begin
                g = 3'b100; dv = 16'h1234; bl = 4'b0000;
            end else if (c < 12) begin
                g = 3'b001; dv = 16'h0BEE; bl = 4'b1000;
            end else begin
                g = 3'b000; dv = 16'h0000; bl = 4'b1111;
            end
            e.v = ev(g, dv, bl);
            e.np_gnt = (c < 12) ? 3'b100 : (c == 12) ? 3'b001 : 3'b000;
            e.nlz_blank = 4'b0000;
            sb.push_back(e);
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if (obs_m !== e.v) begin
                failures++;
                $display("FAIL preempt c=%0d got=%h want=%h", c, obs_m, e.v);
            end
            checks++;
            if (g_n !== e.np_gnt) begin
                failures++;
                $display("FAIL preempt_off c=%0d got=%b want=%b", c, g_n, e.np_gnt);
            end
        end
    endtask

    task automatic test_blanking();
        exp_t e;
        logic [3:0] bl;
        do_reset();
        d1 = 16'h00A5; d2 = 16'h1234;
        for (int c = 0; c < 6; c++) begin
            req = (c < 5) ? 3'b001 : 3'b000;
            case (c)
                0:       begin d0 = 16'h0000; bl = 4'b1110; end
                1:       begin d0 = 16'h1000; bl = 4'b0000; end
                2:       begin d0 = 16'h000F; bl = 4'b1110; end
                3:       begin d0 = 16'h0010; bl = 4'b1100; end
                4:       begin d0 = 16'h0300; bl = 4'b1000; end
                default: begin d0 = 16'h0300; bl = 4'b1111; end
            endcase
            e.v = (c < 5) ? ev(3'b001, d0, bl) : ev(3'b000, 16'h0000, 4'b1111);
            e.np_gnt = (c < 5) ? 3'b001 : 3'b000;
            e.nlz_blank = (c < 5) ? 4'b0000 : 4'b1111;
            sb.push_back(e);
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if (obs_m !== e.v) begin
                failures++;
                $display("FAIL blank c=%0d got=%h want=%h", c, obs_m, e.v);
            end
            checks++;
            if (bl_z !== e.nlz_blank) begin
                failures++;
                $display("FAIL blank_lz_off c=%0d got=%b want=%b", c, bl_z, e.nlz_blank);
            end
        end
    endtask

    // Reset while owner 1 is open; afterwards the pick restarts from index 0,
    // so with 1 and 2 requesting, 1 wins.
    task automatic test_reset_mid();
        exp_t e;
        do_reset();
        d0 = 16'h0BEE; d1 = 16'h00A5; d2 = 16'h1234;
        for (int c = 0; c < 15; c++) begin
            nrst = (c != 12);
            req  = (c < 12) ? 3'b010 : 3'b110;
            e.v = (c == 12) ? ev(3'b000, 16'h0000, 4'b1111) : ev(3'b010, 16'h00A5, 4'b1100);
            e.np_gnt = (c == 12) ? 3'b000 : 3'b010;
            e.nlz_blank = (c == 12) ? 4'b1111 : 4'b0000;
            sb.push_back(e);
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if (obs_m !== e.v) begin
                failures++;
                $display("FAIL reset_mid c=%0d got=%h want=%h", c, obs_m, e.v);
            end
        end
        req = 3'b000;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        nrst = 1'b0;
        req  = '0;
        d0 = '0; d1 = '0; d2 = '0;
        test_reset();
        test_grant_hold();
        test_preempt();
        test_blanking();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
